// File: rtl/pe_dispatcher_pkg.sv
// pe_dispatcher_pkg: shared state encoding and window geometry helpers for PE dispatch.
package pe_dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        ARM   = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } disp_state_e;

    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    function automatic int n_win(input int rows, input int cols, input int k);
        return out_dim(rows, k) * out_dim(cols, k);
    endfunction

    // Cycles a matching PE holds done low after a start: one clear plus K*K calc cycles.
    function automatic int pe_busy_cycles(input int k);
        return k * k + 1;
    endfunction

endpackage

// File: rtl/pe_dispatcher_win_index_counter.sv
// pe_dispatcher_win_index_counter: row-major 2-D window origin counter with clear, advance and last flag.
module pe_dispatcher_win_index_counter #(
    parameter int ROWS = 3,
    parameter int COLS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        adv_i,
    output logic [31:0] row_o,
    output logic [31:0] col_o,
    output logic        last_o
);
    logic [31:0] row_q, row_d, col_q, col_d;
    logic        col_wrap;

    always_comb begin
        col_wrap = col_q == 32'(COLS - 1);
        last_o   = col_wrap && row_q == 32'(ROWS - 1);
        col_d    = clr_i ? '0 : adv_i ? (col_wrap ? '0 : col_q + 32'd1) : col_q;
        row_d    = clr_i ? '0 : (adv_i && col_wrap) ? row_q + 32'd1 : row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;
endmodule

// File: rtl/pe_dispatcher.sv
// pe_dispatcher: walks every kernel-window origin, runs one PE start/done handshake per window
// and strobes the result into the output buffer at the linear output address.
module pe_dispatcher
    import pe_dispatcher_pkg::*;
#(
    parameter int IMG_ROWS    = 6,
    parameter int IMG_COLS    = 6,
    parameter int KERNEL_SIZE = 4,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              pe_done,
    output logic              pe_start,
    output logic [31:0]       win_row,
    output logic [31:0]       win_col,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              finished
);
    localparam int OUT_ROWS = out_dim(IMG_ROWS, KERNEL_SIZE);
    localparam int OUT_COLS = out_dim(IMG_COLS, KERNEL_SIZE);

    disp_state_e state_q, state_d;
    logic        finished_q, finished_d;
    logic        clr, adv, last;

    pe_dispatcher_win_index_counter #(
        .ROWS(OUT_ROWS),
        .COLS(OUT_COLS)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .adv_i (adv),
        .row_o (win_row),
        .col_o (win_col),
        .last_o(last)
    );

    // ARM exists because done is already high when the PE is idle; only a fall then rise means completion.
    always_comb begin
        state_d    = state_q;
        finished_d = finished_q;
        clr        = 1'b0;
        adv        = 1'b0;
        case (state_q)
            IDLE:  if (go) begin
                state_d    = ISSUE;
                finished_d = 1'b0;
                clr        = 1'b1;
            end
            ISSUE: state_d = ARM;
            ARM:   if (!pe_done) state_d = WAIT;
            WAIT:  if (pe_done) state_d = WRITE;
            WRITE: if (last) begin
                state_d    = IDLE;
                finished_d = 1'b1;
            end else begin
                state_d = ISSUE;
                adv     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            finished_q <= finished_d;
        end
    end

    assign pe_start = state_q == ISSUE;
    assign wr_en    = state_q == WRITE;
    assign busy     = state_q != IDLE;
    assign finished = finished_q;
    assign wr_addr  = ADDR_W'(win_row * 32'(OUT_COLS) + win_col);
endmodule
